// File: rtl/shreg_ctrl_pkg.sv
// rtl/shreg_ctrl_pkg.sv - shared constants for the shift-register sequencer
//
// Purpose: opcode encodings, 2-bit FSM state encodings, default step-count
//          width, and the opcode-to-mode-select mapping used by shreg_ctrl.
// Ports:   none (package).
package shreg_ctrl_pkg;

  localparam int SHC_CNT_W_DEFAULT = 4;

  // Command opcodes carried on CMD_OP
  localparam logic [1:0] SHC_OP_LOAD  = 2'b00;
  localparam logic [1:0] SHC_OP_SHIFT = 2'b01;
  localparam logic [1:0] SHC_OP_ROT   = 2'b10;
  localparam logic [1:0] SHC_OP_HOLD  = 2'b11;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // {MODO1, MODO0} that the register needs while executing an opcode.
  // LOAD picks the parallel input, ROTATE the circular input, SHIFT the
  // serial input. HOLD never reaches a state that applies modes.
  function automatic logic [1:0] op_modes(input logic [1:0] op);
    logic [1:0] m;
    m = 2'b00;
    if (op == SHC_OP_LOAD) m = 2'b10;
    else if (op == SHC_OP_ROT) m = 2'b01;
    else if (op == SHC_OP_SHIFT) m = 2'b00;
    return m;
  endfunction

endpackage

// File: rtl/shreg_ctrl_if.sv
// rtl/shreg_ctrl_if.sv - command channel between a command source and shreg_ctrl
//
// Purpose: groups the valid/ready command handshake and its payload.
// Signals: CMD_VALID, CMD_READY, CMD_OP[1:0], CMD_DIR, CMD_COUNT[CNT_W-1:0].
// Modports: master = command source, slave = shreg_ctrl.
interface shreg_ctrl_if #(
  parameter int CNT_W = 4
);

  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic             CMD_DIR;
  logic [CNT_W-1:0] CMD_COUNT;

  modport master (
    output CMD_VALID, CMD_OP, CMD_DIR, CMD_COUNT,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DIR, CMD_COUNT,
    output CMD_READY
  );

endinterface

// File: rtl/shreg_step_cnt.sv
// rtl/shreg_step_cnt.sv - remaining-step down-counter for shreg_ctrl
//
// Purpose: CNT_W-bit down-counter with synchronous clear (highest priority),
//          synchronous load and decrement enable; flags the final step.
// Ports:   CLK      in  clock
//          clr      in  synchronous clear to zero
//          load     in  load load_val
//          load_val in  value to load [CNT_W]
//          dec      in  decrement by one
//          count    out current count [CNT_W]
//          last     out count == 1
module shreg_step_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shreg_ctrl.sv
// rtl/shreg_ctrl.sv - command sequencer for the 4-bit universal shift register
//
// Purpose: accepts one LOAD/SHIFT/ROTATE/HOLD command at a time and drives
//          the register's ENB/DIR/MODO1/MODO0 for exactly the required
//          number of cycles, then pulses DONE. All outputs are registered.
// Ports:   CLK       in  clock
//          RESET     in  synchronous active-high reset
//          cmd       slave command channel (CMD_VALID/READY/OP/DIR/COUNT)
//          ENB       out register enable
//          DIR       out register direction (latched CMD_DIR)
//          MODO1     out 1 = parallel load D
//          MODO0     out 1 = circular input, 0 = serial input S_IN
//          BUSY      out command in progress
//          DONE      out one-cycle completion pulse
//          STEP_CNT  out remaining steps [CNT_W]
// Build option: SHREG_CTRL_PWRCNT_EN adds activity accounting into
//          letest.m1.PwrCntr[PwrC] (one count per ENB cycle and per DONE).
module shreg_ctrl
  import shreg_ctrl_pkg::*;
#(
  parameter int PwrC  = 0,
  parameter int CNT_W = SHC_CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  shreg_ctrl_if.slave      cmd,
  output logic             ENB,
  output logic             DIR,
  output logic             MODO1,
  output logic             MODO0,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] STEP_CNT
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       ready_q;
  logic       accept;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_last;
  logic       mode_load;

  assign cmd.CMD_READY = ready_q;
  assign accept        = cmd.CMD_VALID && ready_q;

  shreg_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .CLK      (CLK),
    .clr      (RESET),
    .load     (cnt_load),
    .load_val (cmd.CMD_COUNT),
    .dec      (cnt_dec),
    .count    (STEP_CNT),
    .last     (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    mode_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.CMD_OP)
            SHC_OP_LOAD: begin
              state_nxt = ST_LOAD;
              mode_load = 1'b1;
            end
            SHC_OP_HOLD: state_nxt = ST_FIN;
            default: begin
              // SHIFT / ROTATE: a zero count completes without touching the register
              if (cmd.CMD_COUNT != '0) begin
                state_nxt = ST_SHIFT;
                cnt_load  = 1'b1;
                mode_load = 1'b1;
              end else begin
                state_nxt = ST_FIN;
              end
            end
          endcase
        end
      end
      ST_LOAD:  state_nxt = ST_FIN;
      ST_SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_nxt = ST_FIN;
      end
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe and never glitch.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      ready_q <= 1'b1;
      BUSY    <= 1'b0;
      ENB     <= 1'b0;
      DONE    <= 1'b0;
      DIR     <= 1'b0;
      MODO1   <= 1'b0;
      MODO0   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      BUSY    <= (state_nxt != ST_IDLE);
      ENB     <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT);
      DONE    <= (state_nxt == ST_FIN);
      if (accept) DIR <= cmd.CMD_DIR;
      // Mode selects only change when the register is about to be enabled;
      // otherwise they keep their last values.
      if (mode_load) {MODO1, MODO0} <= op_modes(cmd.CMD_OP);
    end
  end

`ifdef SHREG_CTRL_PWRCNT_EN
  always_ff @(posedge CLK) begin
    if (ENB || DONE) begin
      letest.m1.PwrCntr[PwrC] <= letest.m1.PwrCntr[PwrC] + 1;
    end
  end
`else
  // Without accounting the counter index has no effect; a negative index
  // would be meaningless either way, so nothing is built for it.
  if (PwrC < 0) begin : g_pwrc_idx_unused
  end
`endif

endmodule

// File: tb/tb_shreg_ctrl.sv
// tb/tb_shreg_ctrl.sv - self-checking bench for shreg_ctrl with a 4-bit register model
module tb_shreg_ctrl;
  import shreg_ctrl_pkg::*;

  localparam int CW = 4;

  typedef struct {
    int         enb_n;
    int         done_k;
    logic       modo1;
    logic       modo0;
    logic       dir;
    logic [3:0] q;
    bit         stepped;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enb, dir, modo1, modo0, busy, done;
  logic [CW-1:0] step_cnt;
  logic [3:0]    d_in = 4'b0000;
  logic          s_in = 1'b0;
  logic [3:0]    q = 4'b0000;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  shreg_ctrl_if #(.CNT_W(CW)) cmd_bus ();

  shreg_ctrl #(
    .PwrC  (0),
    .CNT_W (CW)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .cmd      (cmd_bus.slave),
    .ENB      (enb),
    .DIR      (dir),
    .MODO1    (modo1),
    .MODO0    (modo0),
    .BUSY     (busy),
    .DONE     (done),
    .STEP_CNT (step_cnt)
  );

  always #5 clk = ~clk;

  // 4-bit register: DIR=1 moves bits toward the LSB, DIR=0 toward the MSB
  always @(posedge clk) begin
    if (enb) begin
      if (modo1)    q <= d_in;
      else if (dir) q <= {(modo0 ? q[0] : s_in), q[3:1]};
      else          q <= {q[2:0], (modo0 ? q[3] : s_in)};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic d, input logic [CW-1:0] n,
                       input logic [3:0] dv, input logic si, input bit keep_valid);
    int w;
    w = 0;
    d_in = dv;
    s_in = si;
    cmd_bus.CMD_OP    = op;
    cmd_bus.CMD_DIR   = d;
    cmd_bus.CMD_COUNT = n;
    cmd_bus.CMD_VALID = 1'b1;
    while (cmd_bus.CMD_READY !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (w >= 50) begin
      failures++;
      $display("FAIL issue_ready got=%b exp=1", cmd_bus.CMD_READY);
    end
    tick();
    if (!keep_valid) cmd_bus.CMD_VALID = 1'b0;
  endtask

  task automatic observe(input string name);
    exp_t       e;
    int         enb_seen, done_at, ctl_err, step_err, rdy_err;
    logic       dir_at_done;
    logic [3:0] q_at_done;
    enb_seen = 0; done_at = 0; ctl_err = 0; step_err = 0; rdy_err = 0;
    dir_at_done = 1'bx; q_at_done = 4'bxxxx;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty got=0 exp>=1", name);
      return;
    end
    e = sb.pop_front();
    for (int k = 1; k <= 40; k++) begin
      if (cmd_bus.CMD_READY !== 1'b0 || busy !== 1'b1) rdy_err++;
      if (enb === 1'b1) begin
        enb_seen++;
        if (modo1 !== e.modo1 || modo0 !== e.modo0 || dir !== e.dir) ctl_err++;
        if (e.stepped && step_cnt !== CW'(e.enb_n - k + 1)) step_err++;
      end
      if (done === 1'b1) begin
        done_at = k;
        dir_at_done = dir;
        q_at_done = q;
        break;
      end
      tick();
    end
    if (done_at !== e.done_k) begin
      failures++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_at, e.done_k);
    end
    checks++;
    if (enb_seen !== e.enb_n) begin
      failures++;
      $display("FAIL %s enb_cycles got=%0d exp=%0d", name, enb_seen, e.enb_n);
    end
    checks++;
    if (ctl_err !== 0) begin
      failures++;
      $display("FAIL %s modes_during_enb bad_cycles got=%0d exp=0 (m1=%b m0=%b dir=%b)",
               name, ctl_err, e.modo1, e.modo0, e.dir);
    end
    checks++;
    if (step_err !== 0) begin
      failures++;
      $display("FAIL %s step_cnt bad_cycles got=%0d exp=0", name, step_err);
    end
    checks++;
    if (rdy_err !== 0) begin
      failures++;
      $display("FAIL %s ready_busy_while_active bad_cycles got=%0d exp=0", name, rdy_err);
    end
    checks++;
    if (dir_at_done !== e.dir) begin
      failures++;
      $display("FAIL %s dir_at_done got=%b exp=%b", name, dir_at_done, e.dir);
    end
    checks++;
    if (q_at_done !== e.q) begin
      failures++;
      $display("FAIL %s reg_content got=%b exp=%b", name, q_at_done, e.q);
    end
    tick();
    checks++;
    if (cmd_bus.CMD_READY !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || enb !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done ready/busy/done/enb got=%b%b%b%b exp=1000",
               name, cmd_bus.CMD_READY, busy, done, enb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_bus.CMD_VALID = 1'b1;
    cmd_bus.CMD_OP    = SHC_OP_SHIFT;
    cmd_bus.CMD_DIR   = 1'b1;
    cmd_bus.CMD_COUNT = 4'd5;
    tick();
    tick();
    checks++;
    if (cmd_bus.CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_bus.CMD_READY); end
    checks++;
    if (enb !== 1'b0) begin failures++; $display("FAIL reset_enb got=%b exp=0", enb); end
    checks++;
    if ({dir, modo1, modo0} !== 3'b000) begin failures++; $display("FAIL reset_dir_modes got=%b exp=000", {dir, modo1, modo0}); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++;
    if (step_cnt !== 4'd0) begin failures++; $display("FAIL reset_step_cnt got=%0d exp=0", step_cnt); end
    cmd_bus.CMD_VALID = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept busy got=%b exp=0", busy); end
  endtask

  task automatic test_load();
    sb.push_back('{enb_n: 1, done_k: 2, modo1: 1'b1, modo0: 1'b0, dir: 1'b0, q: 4'b1011, stepped: 1'b0});
    issue(SHC_OP_LOAD, 1'b0, 4'd7, 4'b1011, 1'b0, 1'b0);
    observe("load");
  endtask

  task automatic test_rotate();
    sb.push_back('{enb_n: 4, done_k: 5, modo1: 1'b0, modo0: 1'b1, dir: 1'b0, q: 4'b1011, stepped: 1'b1});
    issue(SHC_OP_ROT, 1'b0, 4'd4, 4'b0000, 1'b0, 1'b0);
    observe("rotate4");
  endtask

  task automatic test_shift();
    sb.push_back('{enb_n: 3, done_k: 4, modo1: 1'b0, modo0: 1'b0, dir: 1'b1, q: 4'b0001, stepped: 1'b1});
    issue(SHC_OP_SHIFT, 1'b1, 4'd3, 4'b0000, 1'b0, 1'b0);
    observe("shift3");
    sb.push_back('{enb_n: 1, done_k: 2, modo1: 1'b0, modo0: 1'b1, dir: 1'b1, q: 4'b1000, stepped: 1'b1});
    issue(SHC_OP_ROT, 1'b1, 4'd1, 4'b0000, 1'b0, 1'b0);
    observe("rotate1");
  endtask

  task automatic test_zero_and_hold();
    sb.push_back('{enb_n: 0, done_k: 1, modo1: 1'b0, modo0: 1'b1, dir: 1'b1, q: 4'b1000, stepped: 1'b0});
    issue(SHC_OP_HOLD, 1'b1, 4'd9, 4'b1111, 1'b1, 1'b0);
    observe("hold");
    sb.push_back('{enb_n: 0, done_k: 1, modo1: 1'b0, modo0: 1'b1, dir: 1'b0, q: 4'b1000, stepped: 1'b0});
    issue(SHC_OP_SHIFT, 1'b0, 4'd0, 4'b1111, 1'b1, 1'b0);
    observe("shift0");
  endtask

  task automatic test_max_count();
    sb.push_back('{enb_n: 15, done_k: 16, modo1: 1'b0, modo0: 1'b0, dir: 1'b0, q: 4'b1111, stepped: 1'b1});
    issue(SHC_OP_SHIFT, 1'b0, 4'd15, 4'b0000, 1'b1, 1'b0);
    observe("shift15");
  endtask

  task automatic test_back_to_back();
    sb.push_back('{enb_n: 2, done_k: 3, modo1: 1'b0, modo0: 1'b0, dir: 1'b0, q: 4'b1100, stepped: 1'b1});
    sb.push_back('{enb_n: 5, done_k: 6, modo1: 1'b0, modo0: 1'b1, dir: 1'b1, q: 4'b0110, stepped: 1'b1});
    issue(SHC_OP_SHIFT, 1'b0, 4'd2, 4'b0000, 1'b0, 1'b1);
    // Payload changes while busy must not affect the running command
    cmd_bus.CMD_OP    = SHC_OP_ROT;
    cmd_bus.CMD_DIR   = 1'b1;
    cmd_bus.CMD_COUNT = 4'd5;
    observe("b2b_first");
    tick();
    cmd_bus.CMD_VALID = 1'b0;
    observe("b2b_second");
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    issue(SHC_OP_SHIFT, 1'b1, 4'd15, 4'b0000, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (enb !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_enb_done got=%b%b exp=00", enb, done); end
    checks++;
    if (step_cnt !== 4'd0) begin failures++; $display("FAIL midreset_step_cnt got=%0d exp=0", step_cnt); end
    checks++;
    if (cmd_bus.CMD_READY !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_ready_busy got=%b%b exp=10", cmd_bus.CMD_READY, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || enb === 1'b1) done_seen++;
      tick();
    end
    checks++;
    if (done_seen !== 0) begin failures++; $display("FAIL midreset_quiet active_cycles got=%0d exp=0", done_seen); end
  endtask

  initial begin
    rst = 1'b1;
    cmd_bus.CMD_VALID = 1'b0;
    cmd_bus.CMD_OP    = 2'b00;
    cmd_bus.CMD_DIR   = 1'b0;
    cmd_bus.CMD_COUNT = '0;
    test_reset();
    test_load();
    test_rotate();
    test_shift();
    test_zero_and_hold();
    test_max_count();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
